// File: rtl/moore_stream_ctrl_pkg.sv
// Shared types and defaults for the Moore detector stimulus controller.
// Holds the FSM state encoding and default word/counter widths.
package moore_ctrl_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a bit index into a w-bit word, never below one bit.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/moore_stream_ctrl_if.sv
// Bundle between host decode, the stream controller and the detector core.
// master = host/detector side, slave = the controller itself.
interface moore_stream_ctrl_if #(
  parameter int WORD_W = moore_ctrl_pkg::WORD_W_DEF,
  parameter int CNT_W  = moore_ctrl_pkg::CNT_W_DEF
);

  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              bit_out;
  logic              bit_valid;
  logic              det_in;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  det_count;
  logic              det_seen;

  modport master (
    output start,
    output word_in,
    output det_in,
    input  bit_out,
    input  bit_valid,
    input  busy,
    input  done,
    input  det_count,
    input  det_seen
  );

  modport slave (
    input  start,
    input  word_in,
    input  det_in,
    output bit_out,
    output bit_valid,
    output busy,
    output done,
    output det_count,
    output det_seen
  );

endinterface

// File: rtl/moore_stream_ctrl_counter.sv
// Detection counter with sticky seen flag for the stream controller.
// MOORE_CNT_SAT_EN defined: saturate at all-ones; otherwise wrap.
module moore_det_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             clr_i,
  input  logic             hit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             seen_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             seen_q, seen_d;
`ifdef MOORE_CNT_SAT_EN
  logic             at_max;

  assign at_max = &count_q;
`endif

  // Clear on word accept wins over a hit in the same cycle.
  always_comb begin
    count_d = count_q;
    seen_d  = seen_q;
    priority case (1'b1)
      clr_i: begin
        count_d = '0;
        seen_d  = 1'b0;
      end
      hit_i: begin
`ifdef MOORE_CNT_SAT_EN
        if (!at_max) count_d = count_q + 1'b1;
`else
        count_d = count_q + 1'b1;
`endif
        seen_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter and flag only move on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      seen_q  <= 1'b0;
    end else if (ena_i) begin
      count_q <= count_d;
      seen_q  <= seen_d;
    end
  end

  assign count_o = count_q;
  assign seen_o  = seen_q;

endmodule

// File: rtl/moore_stream_ctrl.sv
// Streams a latched word MSB-first into the Moore detector and counts hits.
// Counter overflow mode selected by MOORE_CNT_SAT_EN (see counter file).
module moore_stream_ctrl
  import moore_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  moore_stream_ctrl_if.slave  io
);

  localparam int            IW      = idx_w(WORD_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(WORD_W - 1);

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [IW-1:0]     idx_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;

  logic              bit_valid;
  logic              accept;
  logic              hit;

  // Serial bit is decoded straight from state so ena low drops it at once.
  assign bit_valid    = ena && (state_q == SHIFT);
  assign io.bit_valid = bit_valid;
  assign io.bit_out   = bit_valid && shreg_q[idx_q];

  assign accept = ena && (state_q == IDLE) && io.start;
  assign hit    = valid_q && io.det_in;

  assign io.busy = busy_q;
  assign io.done = done_q;

  // Sequencer: accept, shift, wait for last response, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (ena) begin
      valid_q <= bit_valid;
      unique case (state_q)
        IDLE: begin
          if (io.start) begin
            shreg_q <= io.word_in;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx_q == '0) begin
            state_q <= WAIT;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        WAIT: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  moore_det_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena_i   (ena),
    .clr_i   (accept),
    .hit_i   (hit),
    .count_o (io.det_count),
    .seen_o  (io.det_seen)
  );

endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Scoreboard bench for moore_stream_ctrl: CNT_W=4 and CNT_W=2 side by side.
// Expected counts follow MOORE_CNT_SAT_EN the same way the build does.
module tb_moore_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [7:0] word_in = '0;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    int done_cyc;
    int cnt4;
    int cnt2;
    int seen;
  } exp_t;

  exp_t sb[$];
  logic bitq[$];

  moore_stream_ctrl_if #(.WORD_W(8), .CNT_W(4)) ia ();
  moore_stream_ctrl_if #(.WORD_W(8), .CNT_W(2)) ib ();

  assign ia.start   = start;
  assign ia.word_in = word_in;
  assign ib.start   = start;
  assign ib.word_in = word_in;

  moore_stream_ctrl #(.WORD_W(8), .CNT_W(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .io    (ia.slave)
  );

  moore_stream_ctrl #(.WORD_W(8), .CNT_W(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .io    (ib.slave)
  );

  always #5 clk = ~clk;

  // Detector models: response = previous accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ia.det_in <= 1'b0;
    else if (ia.bit_valid) ia.det_in <= ia.bit_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ib.det_in <= 1'b0;
    else if (ib.bit_valid) ib.det_in <= ib.bit_out;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bo_a"}, int'(ia.bit_out), 0);
    chk({tag, "_bv_a"}, int'(ia.bit_valid), 0);
    chk({tag, "_busy_a"}, int'(ia.busy), 0);
    chk({tag, "_done_a"}, int'(ia.done), 0);
    chk({tag, "_cnt_a"}, int'(ia.det_count), 0);
    chk({tag, "_seen_a"}, int'(ia.det_seen), 0);
    chk({tag, "_busy_b"}, int'(ib.busy), 0);
    chk({tag, "_bv_b"}, int'(ib.bit_valid), 0);
    chk({tag, "_cnt_b"}, int'(ib.det_count), 0);
  endtask

  task automatic run_word(input logic [7:0] w, input int off_at,
                          input int off_len, input int glitch_at,
                          input int rst_at);
    exp_t e;
    exp_t got;
    int   pc;
    int   nb;
    int   en_cnt;
    bit   fin;
    bit   was_rst;
    logic eb;
    logic exp_v;

    pc = $countones(w);
    e.done_cyc = 10 + off_len;
    e.cnt4 = pc;
`ifdef MOORE_CNT_SAT_EN
    e.cnt2 = (pc > 3) ? 3 : pc;
`else
    e.cnt2 = pc % 4;
`endif
    e.seen = int'(pc != 0);
    sb.push_back(e);
    for (int i = 7; i >= 0; i--) bitq.push_back(w[i]);

    @(negedge clk);
    ena = 1'b1;
    word_in = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    word_in = ~w;

    nb = 0;
    en_cnt = 0;
    fin = 1'b0;
    was_rst = 1'b0;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      ena = !(off_len > 0 && cyc >= off_at && cyc < off_at + off_len);
      start = (cyc == glitch_at);
      if (ena) en_cnt++;
      exp_v = ena && en_cnt >= 1 && en_cnt <= 8;
      @(negedge clk);

      chk("bv_a", int'(ia.bit_valid), int'(exp_v));
      chk("bv_b", int'(ib.bit_valid), int'(exp_v));
      if (exp_v) begin
        eb = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
        chk("bit_a", int'(ia.bit_out), int'(eb));
        chk("bit_b", int'(ib.bit_out), int'(eb));
        nb++;
      end else begin
        chk("bit_idle_a", int'(ia.bit_out), 0);
      end
      chk("busy_a", int'(ia.busy), int'(cyc < e.done_cyc));
      chk("busy_b", int'(ib.busy), int'(cyc < e.done_cyc));
      chk("done_a", int'(ia.done), int'(cyc == e.done_cyc));
      chk("done_b", int'(ib.done), int'(cyc == e.done_cyc));

      if (ia.done) begin
        if (sb.size() > 0) begin
          got = sb.pop_front();
          chk("cnt_a", int'(ia.det_count), got.cnt4);
          chk("cnt_b", int'(ib.det_count), got.cnt2);
          chk("seen_a", int'(ia.det_seen), got.seen);
          chk("seen_b", int'(ib.det_seen), got.seen);
        end else begin
          chk("sb_underflow", 1, 0);
        end
      end

      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy_a", int'(ia.busy), 0);
        chk("rst_bv_a", int'(ia.bit_valid), 0);
        chk("rst_cnt_a", int'(ia.det_count), 0);
        chk("rst_busy_b", int'(ib.busy), 0);
        chk("rst_cnt_b", int'(ib.det_count), 0);
        sb.delete();
        bitq.delete();
        #2;
        rst_n = 1'b1;
        start = 1'b0;
        ena = 1'b1;
        was_rst = 1'b1;
        fin = 1'b1;
      end else if (cyc == e.done_cyc) begin
        fin = 1'b1;
      end

      if (!fin) begin
        @(posedge clk);
        #1;
      end
    end

    start = 1'b0;
    ena = 1'b1;
    if (!was_rst) chk("nbits", nb, 8);
    @(posedge clk);
    #1;
    chk("post_busy_a", int'(ia.busy), 0);
    chk("post_done_a", int'(ia.done), 0);
    chk("post_busy_b", int'(ib.busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_busy_a", int'(ia.busy), 0);
    chk("rel_bv_a", int'(ia.bit_valid), 0);

    run_word(8'hB6, 0, 0, 0, 0);
    run_word(8'h00, 0, 0, 0, 0);
    run_word(8'hFF, 4, 3, 0, 0);
    run_word(8'hFF, 0, 0, 0, 5);
    run_word(8'hB6, 0, 0, 0, 0);
    run_word(8'hFF, 0, 0, 5, 0);
    run_word(8'(($urandom_range(0, 255))), 0, 0, 0, 0);
    run_word(8'(($urandom_range(0, 255))), 2, 2, 3, 0);

    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/moore_stream_ctrl.md
# moore_stream_ctrl

Serial stimulus controller for the Moore sequence-detector core in the top-level TinyTapeout wrapper. It latches a parallel word and streams it MSB-first into the detector one bit per enabled cycle. It samples the detector's registered Moore output one cycle after each bit, counts detections per word and signals completion with a busy/done handshake. It sits between the `ui_in` pin decode and the detector core and is the only driver of the detector's serial input.

## Interface
- `WORD_W`, 8: bits per streamed word (≥2).
- `CNT_W`, 4: width of the detection counter.
- `clk` in 1: single design clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global enable; low freezes all state.
- `start` in 1: request to stream `word_in`; sampled only in IDLE.
- `word_in` in WORD_W: word to stream; latched on start acceptance.
- `bit_out` out 1: serial bit to the detector.
- `bit_valid` out 1: `bit_out` is meaningful this cycle; the detector advances only when this is high.
- `det_in` in 1: registered Moore output of the detector.
- `busy` out 1: high in SHIFT and WAIT.
- `done` out 1: one-cycle pulse in DONE.
- `det_count` out CNT_W: detections during the current or last word.
- `det_seen` out 1: sticky; at least one detection during the current or last word.

## Operation
- States: IDLE, SHIFT, WAIT, DONE.
- IDLE, with `start` and `ena` high:
  - latch `word_in` into the shift register;
  - set bit index to WORD_W-1;
  - clear `det_count` and `det_seen`;
  - go to SHIFT.
- In IDLE, `start` with `ena` low is ignored.
- SHIFT:
  - `bit_out` = shreg[idx] and `bit_valid` = 1;
  - decrement idx each enabled cycle;
  - at idx==0, go to WAIT.
- WAIT: one cycle to sample the response to the last bit, then go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE unconditionally. `start` is ignored in SHIFT, WAIT and DONE.
- Detection sampling:
  - `valid_d` is `bit_valid` registered on enabled cycles.
  - When `valid_d` = 1 and `det_in` = 1, increment `det_count` and set `det_seen`.
- `ena` low:
  - FSM, idx, shreg, `valid_d` and counter all hold;
  - `bit_valid` is forced 0 and `done` is held at its current value;
  - `det_in` is not sampled.
- Counter overflow behaviour is set by the `MOORE_CNT_SAT_EN` macro (see Configuration).
- `bit_out` is 0 whenever `bit_valid` is 0.

## Timing
- Reset values: state IDLE; `bit_out`, `bit_valid`, `busy`, `done`, `det_seen`, `valid_d` all 0; `det_count` 0.
- Reset takes effect immediately on `rst_n` falling, including mid-word. The detector core shares `rst_n`.
- Cycle numbering assumes `ena` held high, with cycle 0 = the edge that accepts `start`:
  - `busy` = 1 from cycle 1;
  - bits appear in cycles 1..WORD_W;
  - WAIT is cycle WORD_W+1;
  - `done` = 1 and `busy` = 0 in cycle WORD_W+2, with the final `det_count` valid in the same cycle;
  - the earliest next accept is the edge ending cycle WORD_W+3.
- Each `ena`-low cycle extends the sequence by exactly one cycle.
- All outputs are registered except `bit_out`/`bit_valid`, which are decoded from state and shreg.

## Configuration
- `MOORE_CNT_SAT_EN` defined: `det_count` saturates at 2^CNT_W-1 and further detections leave it unchanged.
- `MOORE_CNT_SAT_EN` not defined: `det_count` wraps modulo 2^CNT_W.
- `det_seen` behaves identically in both builds.

## Structure
- Package `moore_ctrl_pkg`:
  - state typedef (IDLE=2'd0, SHIFT=2'd1, WAIT=2'd2, DONE=2'd3);
  - default `WORD_W`/`CNT_W` constants.
- Sub-module `moore_det_counter` holds the increment/clear counter and the sticky flag, parameterised by `CNT_W`, with the saturate/wrap selection inside it.
- The FSM, shift register and `valid_d` stay in `moore_stream_ctrl`.

## Test plan
Bench detector model: `det_in` = previous accepted `bit_out`, registered on `bit_valid`.
- Reset asserted with `ena` = 1 → all outputs 0, state IDLE; deasserting with `start` = 0 keeps `busy` = 0.
- `start` with `word_in` = 8'hB6 → `bit_out` sequence 1,0,1,1,0,1,1,0 in cycles 1..8; `done` in cycle 10; `det_count` = 5; `det_seen` = 1.
- `word_in` = 8'h00 → `done` in cycle 10; `det_count` = 0; `det_seen` = 0; `bit_valid` high exactly 8 cycles.
- 8'hFF with `ena` low for 3 cycles starting at cycle 4 → `bit_valid` low in those cycles; `done` in cycle 13; `det_count` = 8.
- `rst_n` pulsed low in cycle 5 of 8'hFF → `busy`, `bit_valid` and `det_count` are 0 immediately; a new `start` afterwards streams normally.
- `CNT_W` = 2 with 8'hFF → `det_count` = 3 with `MOORE_CNT_SAT_EN` defined, 0 without; `start` pulsed mid-word is ignored in both builds.
